iobus_txn_ctrl: RTL and testbench

IOBUS_TXN_CTRL -- requirements
Module: iobus_txn_ctrl

---
 rtl/iobus_pkg.sv | 25 ++
 rtl/iobus_txn_ctrl_if.sv | 35 +++
 rtl/iobus_timeout_ctr.sv | 35 +++
 rtl/iobus_txn_ctrl.sv | 132 +++++++++++++
 tb/tb_iobus_txn_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iobus_pkg.sv
// Shared definitions for the IO bus transaction controller:
// FSM state encoding, index field width, timeout counter width,
// default error read data and the target index decode helper.
package iobus_pkg;

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Target index field of an IO bus address, starting at bit lsb.
    function automatic logic [IDX_W-1:0] sel_index(input logic [DATA_W-1:0] addr,
                                                   input int unsigned       lsb);
        return IDX_W'(addr >> lsb);
    endfunction

endpackage

// File: rtl/iobus_txn_ctrl_if.sv
// IO bus transaction interface.
// Initiator side : io_addr_strobe, io_read_strobe, io_write_strobe, io_address
//                  (to controller), io_read_data, io_ready (from controller).
// Target side    : tgt_sel, tgt_strobe (from controller), mux_read_data,
//                  mux_ready (merged target responses, to controller).
// master = environment (initiator + target mux), slave = controller.
interface iobus_txn_ctrl_if #(
    parameter int unsigned CORE_COUNT = 2
);
    import iobus_pkg::*;

    logic                  io_addr_strobe;
    logic                  io_read_strobe;
    logic                  io_write_strobe;
    logic [DATA_W-1:0]     io_address;
    logic [DATA_W-1:0]     io_read_data;
    logic                  io_ready;
    logic [CORE_COUNT-1:0] tgt_sel;
    logic                  tgt_strobe;
    logic [DATA_W-1:0]     mux_read_data;
    logic                  mux_ready;

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe, io_address,
               mux_read_data, mux_ready,
        input  io_read_data, io_ready, tgt_sel, tgt_strobe
    );

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe, io_address,
               mux_read_data, mux_ready,
        output io_read_data, io_ready, tgt_sel, tgt_strobe
    );

endinterface

// File: rtl/iobus_timeout_ctr.sv
// WAIT-phase cycle counter.
// Ports: clk, rst (async, active-high); start clears the count; enable
// advances it by one per cycle; limit is the timeout threshold;
// expired (registered) is high while the count equals limit.
module iobus_timeout_ctr
    import iobus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc_c;

    assign cnt_inc_c = CNT_W'(cnt + CNT_W'(1));

    // expired is computed alongside the count so it tracks cnt == limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            expired <= (limit == '0);
        end else if (enable) begin
            cnt     <= cnt_inc_c;
            expired <= (cnt_inc_c == limit);
        end
    end

endmodule

// File: rtl/iobus_txn_ctrl.sv
// IO bus transaction controller: decodes an initiator transaction to a
// one-hot target select, waits for the merged target ready (with timeout),
// and returns a one-cycle io_ready with data or ERR_DATA.
// Ports: clk, rst (async, active-high); bus (slave modport, initiator and
// target-mux signals); err_clr clears the sticky flags; err_timeout,
// err_decode, err_overrun are sticky error flags; err_addr holds the
// address of the most recent errored transaction.
module iobus_txn_ctrl
    import iobus_pkg::*;
#(
    parameter int unsigned       CORE_COUNT     = 2,
    parameter int unsigned       SEL_LSB        = 8,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    iobus_txn_ctrl_if.slave   bus,
    input  logic              err_clr,
    output logic              err_timeout,
    output logic              err_decode,
    output logic              err_overrun,
    output logic [DATA_W-1:0] err_addr
);

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic              err_hold;
    logic [IDX_W-1:0]  idx_c;
    logic              idx_ok_c;
    logic              to_expired;
    logic              set_to_c;
    logic              set_dec_c;
    logic              set_ovr_c;
    logic              unused_qual;

    // Read/write qualifiers do not change how a transaction is handled.
    assign unused_qual = bus.io_read_strobe | bus.io_write_strobe;

    assign idx_c     = sel_index(bus.io_address, SEL_LSB);
    assign idx_ok_c  = (32'(idx_c) < CORE_COUNT);
    assign set_dec_c = (state == ST_IDLE) && bus.io_addr_strobe && !idx_ok_c;
    assign set_to_c  = (state == ST_WAIT) && !bus.mux_ready && to_expired;
    assign set_ovr_c = (state != ST_IDLE) && bus.io_addr_strobe;

    iobus_timeout_ctr u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .start   ((state == ST_IDLE) && bus.io_addr_strobe && idx_ok_c),
        .enable  (state == ST_WAIT),
        .limit   (CNT_W'(TIMEOUT_CYCLES)),
        .expired (to_expired)
    );

    // Transaction FSM with registered bus outputs.
    // A decode error spends one silent ERR cycle (err_hold) before the
    // io_ready pulse, so the initiator sees it two cycles after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            addr_q           <= '0;
            err_hold         <= 1'b0;
            err_addr         <= '0;
            bus.io_ready     <= 1'b0;
            bus.io_read_data <= '0;
            bus.tgt_sel      <= '0;
            bus.tgt_strobe   <= 1'b0;
        end else begin
            bus.io_ready     <= 1'b0;
            bus.io_read_data <= '0;
            bus.tgt_strobe   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.io_addr_strobe) begin
                        addr_q <= bus.io_address;
                        if (idx_ok_c) begin
                            state          <= ST_WAIT;
                            bus.tgt_sel    <= CORE_COUNT'(1) << idx_c;
                            bus.tgt_strobe <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            err_hold <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // A ready on the timeout cycle still counts as success.
                    if (bus.mux_ready) begin
                        state            <= ST_RESP;
                        bus.tgt_sel      <= '0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= bus.mux_read_data;
                    end else if (to_expired) begin
                        state            <= ST_ERR;
                        bus.tgt_sel      <= '0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= ERR_DATA;
                        err_addr         <= addr_q;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (err_hold) begin
                        err_hold         <= 1'b0;
                        bus.io_ready     <= 1'b1;
                        bus.io_read_data <= ERR_DATA;
                        err_addr         <= addr_q;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error event wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_decode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= set_to_c  | (err_timeout & ~err_clr);
            err_decode  <= set_dec_c | (err_decode  & ~err_clr);
            err_overrun <= set_ovr_c | (err_overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_iobus_txn_ctrl.sv
// Self-checking bench for iobus_txn_ctrl: directed scenarios followed by
// random traffic, all checked cycle by cycle against a transaction-level
// reference model (accept cycle, response cycle, sticky flags).
module tb_iobus_txn_ctrl;

    localparam int unsigned CC    = 2;
    localparam int unsigned SL    = 8;
    localparam int          TO    = 4;
    localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        err_timeout;
    logic        err_decode;
    logic        err_overrun;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    iobus_txn_ctrl_if #(.CORE_COUNT(CC)) bus ();

    iobus_txn_ctrl #(
        .CORE_COUNT     (CC),
        .SEL_LSB        (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .err_timeout (err_timeout),
        .err_decode  (err_decode),
        .err_overrun (err_overrun),
        .err_addr    (err_addr)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    // Reference model: one outstanding transaction described by the cycle
    // it was accepted and the cycle its io_ready is due (-1 = not yet known).
    bit          m_busy, m_valid, m_err;
    int          m_acc, m_rdy, m_idx;
    logic [31:0] m_addr, m_data, m_eaddr;
    bit          m_to, m_dec, m_ovr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_err = 0;
        m_acc = 0; m_rdy = -1; m_idx = 0;
        m_addr = '0; m_data = '0; m_eaddr = '0;
        m_to = 0; m_dec = 0; m_ovr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(bus.io_ready),    32'h0);
        check({tag, "_data"},   bus.io_read_data,     32'h0);
        check({tag, "_sel"},    32'(bus.tgt_sel),     32'h0);
        check({tag, "_strobe"}, 32'(bus.tgt_strobe),  32'h0);
        check({tag, "_to"},     32'(err_timeout),     32'h0);
        check({tag, "_dec"},    32'(err_decode),      32'h0);
        check({tag, "_ovr"},    32'(err_overrun),     32'h0);
        check({tag, "_eaddr"},  err_addr,             32'h0);
    endtask

    // Asynchronous reset: outputs must drop without waiting for a clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero({tag, "_held"});
        rst = 1'b0;
    endtask

    // Compare this cycle's outputs with the model, drive this cycle's
    // inputs, advance the model, then move to the next cycle.
    task automatic step(input bit stb, input logic [31:0] addr, input bit rd, input bit wr,
                        input bit mrdy, input logic [31:0] mdat, input bit clr);
        bit          e_rdy, e_stb, idle, s_to, s_dec, s_ovr;
        logic [CC-1:0] e_sel;
        logic [31:0] e_data;
        logic [3:0]  fld;

        e_rdy  = m_busy && (m_rdy == cyc);
        e_data = e_rdy ? (m_err ? ERR_D : m_data) : 32'h0;
        e_sel  = '0;
        if (m_busy && m_valid && cyc > m_acc && (m_rdy < 0 || cyc < m_rdy))
            e_sel = CC'(1) << m_idx;
        e_stb  = m_busy && m_valid && (cyc == m_acc + 1);

        check("io_ready",     32'(bus.io_ready),   32'(e_rdy));
        check("io_read_data", bus.io_read_data,    e_data);
        check("tgt_sel",      32'(bus.tgt_sel),    32'(e_sel));
        check("tgt_strobe",   32'(bus.tgt_strobe), 32'(e_stb));
        check("err_timeout",  32'(err_timeout),    32'(m_to));
        check("err_decode",   32'(err_decode),     32'(m_dec));
        check("err_overrun",  32'(err_overrun),    32'(m_ovr));
        check("err_addr",     err_addr,            m_eaddr);

        bus.io_addr_strobe  = stb;
        bus.io_address      = addr;
        bus.io_read_strobe  = rd;
        bus.io_write_strobe = wr;
        bus.mux_ready       = mrdy;
        bus.mux_read_data   = mdat;
        err_clr             = clr;

        idle  = !m_busy;
        s_to  = 0;
        s_dec = 0;
        s_ovr = 0;
        if (stb && idle) begin
            fld     = addr[SL +: 4];
            m_busy  = 1;
            m_acc   = cyc;
            m_addr  = addr;
            m_idx   = int'(fld);
            m_valid = (m_idx < int'(CC));
            m_err   = !m_valid;
            m_rdy   = m_valid ? -1 : cyc + 2;
            s_dec   = !m_valid;
        end else if (stb) begin
            s_ovr = 1;
        end
        if (m_busy && m_valid && m_rdy < 0 && cyc > m_acc) begin
            if (mrdy) begin
                m_rdy  = cyc + 1;
                m_data = mdat;
            end else if (cyc - (m_acc + 1) == TO) begin
                m_rdy = cyc + 1;
                m_err = 1;
                s_to  = 1;
            end
        end
        if (m_busy && m_err && m_rdy == cyc + 1) m_eaddr = m_addr;
        m_to  = s_to  ? 1'b1 : (clr ? 1'b0 : m_to);
        m_dec = s_dec ? 1'b1 : (clr ? 1'b0 : m_dec);
        m_ovr = s_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
        if (m_busy && m_rdy == cyc) m_busy = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          guard;

        bus.io_addr_strobe  = 1'b0;
        bus.io_read_strobe  = 1'b0;
        bus.io_write_strobe = 1'b0;
        bus.io_address      = '0;
        bus.mux_ready       = 1'b0;
        bus.mux_read_data   = '0;
        err_clr             = 1'b0;
        rst                 = 1'b0;
        model_reset();
        #1;
        do_reset("reset");
        idle(2);

        // Read to target 1 with ready on the third wait cycle
        step(1, 32'h0000_0100, 1, 0, 0, 32'h0, 0);
        check("t044_sel", 32'(bus.tgt_sel), 32'h2);
        idle(2);
        step(0, 32'h0, 0, 0, 1, 32'h1234_5678, 0);
        check("t044_ready", 32'(bus.io_ready), 32'h1);
        check("t044_data",  bus.io_read_data,  32'h1234_5678);
        idle(2);

        // Decode error on an index beyond the last target
        step(1, 32'h0000_0500, 0, 1, 0, 32'h0, 0);
        idle(1);
        check("t045_ready", 32'(bus.io_ready),  32'h1);
        check("t045_data",  bus.io_read_data,   ERR_D);
        check("t045_dec",   32'(err_decode),    32'h1);
        check("t045_eaddr", err_addr,           32'h0000_0500);
        idle(2);

        // Timeout with no ready, then clear flags while err_addr holds
        step(1, 32'h0000_0040, 1, 0, 0, 32'h0, 0);
        idle(5);
        check("t046_ready", 32'(bus.io_ready), 32'h1);
        check("t046_data",  bus.io_read_data,  ERR_D);
        check("t046_to",    32'(err_timeout),  32'h1);
        idle(1);
        step(0, 32'h0, 0, 0, 0, 32'h0, 1);
        check("t046_clr",   32'(err_timeout),  32'h0);
        check("t046_hold",  err_addr,          32'h0000_0040);
        idle(1);

        // Overrun during WAIT (first strobe has no qualifier)
        step(1, 32'h0000_0100, 0, 0, 0, 32'h0, 0);
        step(1, 32'h0000_0000, 1, 0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 0, 1, 32'hA5A5_0001, 0);
        check("t047_ovr",   32'(err_overrun), 32'h1);
        check("t047_data",  bus.io_read_data, 32'hA5A5_0001);
        idle(2);

        // Reset in the middle of WAIT, then a fresh transaction
        step(1, 32'h0000_0100, 1, 0, 0, 32'h0, 0);
        idle(1);
        do_reset("t048_rst");
        idle(1);
        step(1, 32'h0000_0000, 0, 1, 0, 32'h0, 0);
        step(0, 32'h0, 0, 0, 1, 32'h0BAD_F00D, 0);
        check("t048_ready", 32'(bus.io_ready), 32'h1);
        idle(2);

        // Ready in IDLE ignored; ready exactly on the timeout cycle wins
        step(0, 32'h0, 0, 0, 1, 32'h1111_1111, 1);
        step(1, 32'h0000_0100, 1, 0, 1, 32'h2222_2222, 0);
        idle(4);
        step(0, 32'h0, 0, 0, 1, 32'hCAFE_0049, 0);
        check("t049_ready", 32'(bus.io_ready), 32'h1);
        check("t049_data",  bus.io_read_data,  32'hCAFE_0049);
        check("t049_to",    32'(err_timeout),  32'h0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            a[SL +: 4] = 4'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) == 0), a,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) == 0), $urandom,
                 1'($urandom_range(0, 15) == 0));
        end

        guard = 0;
        while (m_busy && guard < 20) begin
            idle(1);
            guard++;
        end
        check("drain", 32'(m_busy), 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
